// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage and the downstream datapath.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    // Fetch FSM state encoding.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HAVE = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

    // Instruction handed to decode together with its address.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    localparam logic [XLEN-1:0] RV_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RV_ALIGN_MASK = 32'h0000_0003;

    // True when an address is not word aligned.
    function automatic logic rv_misaligned(input logic [XLEN-1:0] addr);
        return |(addr & RV_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection (flush_pc / PCTarget / PC+4) and alignment check.
module pc_next_sel
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            pc_src,
    input  logic            flush,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // Sequential successor, wraps modulo 2^32.
    assign pc_plus4 = pc + XLEN'(4);

    // Flush redirect dominates the branch decision.
    always_comb begin
        next_pc = pc_plus4;
        if (flush) begin
            next_pc = flush_pc;
        end else if (pc_src) begin
            next_pc = pc_target;
        end
        misaligned = rv_misaligned(next_pc);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single outstanding imem requests,
// hands fetched words to decode over a valid/ready handshake.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fetch_err
);

    fetch_state_e state_q, state_d;
    fetch_pkt_t   pkt_q, pkt_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         kill_q, kill_d;
    logic         req_q, req_d;

    logic [31:0]  sel_pc;
    logic         sel_misaligned;
    logic         req_fire;

    pc_next_sel u_pc_next_sel (
        .pc         (pkt_q.pc),
        .pc_target  (PCTarget),
        .flush_pc   (flush_pc),
        .pc_src     (PCSrc),
        .flush      (flush),
        .pc_plus4   (PCPlus4),
        .next_pc    (sel_pc),
        .misaligned (sel_misaligned)
    );

    // req_q is only ever high in REQ, so it qualifies the handshake.
    assign req_fire = req_q && imem_req_ready;

    // Next-state and registered-output values.
    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        fetch_pc_d = fetch_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        kill_d     = kill_q;

        if (flush) begin
            if (sel_misaligned) begin
                state_d = ST_ERR;
                err_d   = 1'b1;
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end else begin
                fetch_pc_d = flush_pc;
                valid_d    = 1'b0;
                unique case (state_q)
                    ST_REQ: begin
                        // A request accepted this cycle is still in flight.
                        if (req_fire) begin
                            kill_d  = 1'b1;
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                    ST_WAIT: begin
                        // Response arriving now is the stale one: drop it and refetch.
                        if (imem_rsp_valid) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            kill_d  = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                    default: state_d = ST_REQ;
                endcase
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            pkt_d.instr = imem_rsp_data;
                            pkt_d.pc    = fetch_pc_q;
                            valid_d     = 1'b1;
                            state_d     = ST_HAVE;
                        end
                    end
                end
                ST_HAVE: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        if (sel_misaligned) begin
                            err_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            fetch_pc_d = sel_pc;
                            state_d    = ST_REQ;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end

        req_d = (state_d == ST_REQ);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            pkt_q      <= '{instr: RV_NOP, pc: RESET_PC};
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_q      <= pkt_d;
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            kill_q     <= kill_d;
            req_q      <= req_d;
        end
    end

    assign imem_req_valid = req_q;
    assign imem_addr      = fetch_pc_q;
    assign Instr          = pkt_q.instr;
    assign PC             = pkt_q.pc;
    assign instr_valid    = valid_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_err;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .Instr          (Instr),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: latches accepted requests, answers after lat cycles.
    int          lat = 1;
    logic        ovr = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    int          nreq = 0;
    int          viol_overlap = 0;
    int          viol_wait_req = 0;

    always @(negedge clk) begin
        imem_rsp_valid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend && imem_req_valid) viol_wait_req++;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = ovr ? 32'hDEAD_BEEF : mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (pend) viol_overlap++;
                pend      = 1'b1;
                pend_addr = imem_addr;
                cnt       = lat - 1;
                nreq++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_valid_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_req_timeout"}, 32'(imem_req_valid), 32'd1);
    endtask

    typedef struct {
        logic        ir;
        logic        src;
        logic [31:0] tgt;
        int          lt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b0; PCSrc = 1'b0;
        PCTarget = '0; flush = 1'b0; flush_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // ir src tgt lat | req addr iv pc instr
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0000_0013});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0000_0013});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1, 1'b0, 32'h0,   1'b1, 32'h0,   32'hC0DE_0000});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h4,   1'b0, 32'h0,   32'hC0DE_0000});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1, 1'b0, 32'h4,   1'b0, 32'h0,   32'hC0DE_0000});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1, 1'b0, 32'h4,   1'b1, 32'h4,   32'hC0DE_0004});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h8,   1'b0, 32'h4,   32'hC0DE_0004});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   3, 1'b0, 32'h8,   1'b0, 32'h4,   32'hC0DE_0004});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   3, 1'b0, 32'h8,   1'b0, 32'h4,   32'hC0DE_0004});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   3, 1'b0, 32'h8,   1'b0, 32'h4,   32'hC0DE_0004});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   3, 1'b0, 32'h8,   1'b1, 32'h8,   32'hC0DE_0008});
        vecs.push_back('{1'b1, 1'b1, 32'h100, 3, 1'b1, 32'h100, 1'b0, 32'h8,   32'hC0DE_0008});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h100, 1'b0, 32'h8,   32'hC0DE_0008});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h100, 1'b1, 32'h100, 32'hC0DE_0100});
        for (int k = 0; k < 5; k++)
            vecs.push_back('{1'b0, 1'b0, 32'h0, 1, 1'b0, 32'h100, 1'b1, 32'h100, 32'hC0DE_0100});

        // Reset values
        repeat (3) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc",        PC,                  32'h0);
        chk("rst_pcplus4",   PCPlus4,             32'h4);
        chk("rst_instr",     Instr,               32'h0000_0013);
        chk("rst_valid",     32'(instr_valid),    32'd0);
        chk("rst_err",       32'(fetch_err),      32'd0);
        rst_n = 1'b1;

        // Table: fetch 0/4, slow fetch of 8, branch to 0x100, hold in HAVE
        foreach (vecs[i]) begin
            instr_ready = vecs[i].ir;
            PCSrc       = vecs[i].src;
            PCTarget    = vecs[i].tgt;
            lat         = vecs[i].lt;
            tick();
            chk($sformatf("v%0d_req", i),   32'(imem_req_valid), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid),    32'(vecs[i].e_iv));
            chk($sformatf("v%0d_pc", i),    PC,                  vecs[i].e_pc);
            chk($sformatf("v%0d_pc4", i),   PCPlus4,             vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d_instr", i), Instr,               vecs[i].e_instr);
            chk($sformatf("v%0d_err", i),   32'(fetch_err),      32'd0);
        end

        // Flush in WAIT drops the late response
        begin
            int bad = 0;
            int n = 0;
            instr_ready = 1'b1; PCSrc = 1'b0; lat = 3; ovr = 1'b1;
            tick();
            chk("fl_req_addr", imem_addr, 32'h104);
            instr_ready = 1'b0;
            tick();
            chk("fl_wait_noreq", 32'(imem_req_valid), 32'd0);
            flush = 1'b1; flush_pc = 32'h200;
            tick();
            flush = 1'b0;
            chk("fl_addr", imem_addr, 32'h200);
            chk("fl_noreq", 32'(imem_req_valid), 32'd0);
            while (!imem_req_valid && n < 10) begin
                if (instr_valid) bad++;
                tick();
                n++;
            end
            if (instr_valid) bad++;
            chk("fl_dropped_valid", 32'(bad), 32'd0);
            chk("fl_refetch_req", 32'(imem_req_valid), 32'd1);
            chk("fl_refetch_addr", imem_addr, 32'h200);
            ovr = 1'b0; lat = 1;
            wait_valid("fl");
            chk("fl_pc", PC, 32'h200);
            chk("fl_instr", Instr, 32'hC0DE_0200);
        end

        // PC+4 wraps at the top of the address space
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wr");
        chk("wr_pc", PC, 32'hFFFF_FFFC);
        chk("wr_pc4", PCPlus4, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wr_next_addr", imem_addr, 32'h0);
        chk("wr_err", 32'(fetch_err), 32'd0);
        wait_valid("wr2");
        chk("wr2_pc", PC, 32'h0);

        // Misaligned branch target: sticky error, no further fetches
        begin
            int req_seen = 0;
            int n0;
            instr_ready = 1'b1; PCSrc = 1'b1; PCTarget = 32'h102;
            tick();
            instr_ready = 1'b0; PCSrc = 1'b0;
            chk("er_err", 32'(fetch_err), 32'd1);
            chk("er_valid", 32'(instr_valid), 32'd0);
            n0 = nreq;
            for (int k = 0; k < 4; k++) begin
                if (imem_req_valid) req_seen++;
                tick();
            end
            chk("er_no_req", 32'(req_seen), 32'd0);
            chk("er_no_mem_req", 32'(nreq - n0), 32'd0);
            flush = 1'b1; flush_pc = 32'h41;
            tick();
            chk("er_badflush_req", 32'(imem_req_valid), 32'd0);
            flush_pc = 32'h40;
            tick();
            flush = 1'b0;
            chk("er_resume_req", 32'(imem_req_valid), 32'd1);
            chk("er_resume_addr", imem_addr, 32'h40);
            wait_valid("er");
            chk("er_pc", PC, 32'h40);
            chk("er_instr", Instr, 32'hC0DE_0040);
            chk("er_err_sticky", 32'(fetch_err), 32'd1);
        end

        // Asynchronous reset in the middle of WAIT
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("ar_req_addr", imem_addr, 32'h44);
        lat = 5;
        tick();
        chk("ar_in_wait", 32'(imem_req_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr",  imem_addr,        32'h0);
        chk("ar_pc",    PC,               32'h0);
        chk("ar_instr", Instr,            32'h0000_0013);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_err",   32'(fetch_err),   32'd0);
        lat = 1;
        tick();
        chk("ar_req_in_rst", 32'(imem_req_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_req("ar");
        chk("ar_refetch_addr", imem_addr, 32'h0);
        wait_valid("ar");
        chk("ar_refetch_pc", PC, 32'h0);
        chk("ar_refetch_instr", Instr, 32'hC0DE_0000);

        chk("mem_overlap", 32'(viol_overlap), 32'd0);
        chk("mem_req_in_wait", 32'(viol_wait_req), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
